// File: rtl/fix_avg_accumulator.sv
// Multi-channel fixed-point averaging engine: accumulates signed lane samples,
// forms 1/count with a restoring divider, then streams sum*recip per lane.
module fix_avg_accumulator #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 15,
    parameter int unsigned CNT_W     = 6,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         in_ready,
    input  logic                         finish,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CH_W-1:0]              out_chan,
    output logic                         out_last,
    output logic [CNT_W-1:0]             out_count,
    output logic                         count_sat,
    output logic                         busy
);

    localparam int unsigned ACC_W  = DATA_W + CNT_W;
    localparam int unsigned PROD_W = ACC_W + FRAC_BITS + 1;
    localparam int unsigned Q_W    = FRAC_BITS + 1;
    localparam int unsigned STEP_W = (FRAC_BITS > 0) ? $clog2(FRAC_BITS + 1) : 1;

    localparam logic [CNT_W-1:0]         CNT_MAX  = '1;
    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        RECIP = 2'd1,
        SCALE = 2'd2
    } state_t;

    // Average of one lane: (sum * recip) >>> FRAC_BITS, clamped to DATA_W.
    function automatic logic signed [DATA_W-1:0] scale(
        input logic signed [ACC_W-1:0] s,
        input logic [Q_W-1:0]          r
    );
        logic signed [PROD_W-1:0] p;
        p = (PROD_W'(s) * PROD_W'($signed({1'b0, r}))) >>> FRAC_BITS;
        if (p > PROD_W'(DATA_MAX)) begin
            scale = DATA_MAX;
        end else if (p < PROD_W'(DATA_MIN)) begin
            scale = DATA_MIN;
        end else begin
            scale = DATA_W'(p);
        end
    endfunction

    state_t                  state;
    logic signed [ACC_W-1:0] sum [CHANNELS];
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        rem;
    logic [Q_W-1:0]          quo;
    logic [STEP_W-1:0]       step;

    logic                     accept_c;
    logic                     cnt_full_c;
    logic [CNT_W-1:0]         count_next_c;
    logic [CNT_W:0]           rem_shift_c;
    logic                     div_ge_c;
    logic [CH_W-1:0]          chan_next_c;
    logic [CH_W-1:0]          beat_chan_c;
    logic signed [DATA_W-1:0] beat_data_c;

    assign out_count = count;

    // Sample acceptance, one restoring-divide step and the next beat's result.
    always_comb begin
        accept_c     = in_valid && (state == ACCUM);
        cnt_full_c   = (count == CNT_MAX);
        count_next_c = (accept_c && !cnt_full_c) ? count + CNT_W'(1) : count;
        rem_shift_c  = {rem, quo[Q_W-1]};
        div_ge_c     = (rem_shift_c >= {1'b0, count});
        chan_next_c  = out_chan + CH_W'(1);
        beat_chan_c  = out_valid ? chan_next_c : '0;
        beat_data_c  = scale(sum[beat_chan_c], quo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                sum[c] <= '0;
            end
            count     <= '0;
            count_sat <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            step      <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        if (cnt_full_c) begin
                            count_sat <= 1'b1;
                        end else begin
                            count <= count_next_c;
                            for (int unsigned c = 0; c < CHANNELS; c++) begin
                                sum[c] <= sum[c] + ACC_W'($signed(in_data[c*DATA_W +: DATA_W]));
                            end
                        end
                    end
                    // A sample arriving with finish is counted before the divide starts.
                    if (finish) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        rem      <= '0;
                        step     <= '0;
                        if (count_next_c == '0) begin
                            quo   <= '0;
                            state <= SCALE;
                        end else begin
                            quo   <= Q_W'(1) << FRAC_BITS;
                            state <= RECIP;
                        end
                    end
                end

                RECIP: begin
                    // quo shifts numerator bits out of its MSB and quotient bits in at its LSB.
                    rem  <= div_ge_c ? CNT_W'(rem_shift_c - {1'b0, count}) : CNT_W'(rem_shift_c);
                    quo  <= {quo[Q_W-2:0], div_ge_c};
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(FRAC_BITS)) begin
                        state <= SCALE;
                    end
                end

                SCALE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_chan  <= '0;
                        out_last  <= (CHANNELS == 1);
                        out_data  <= beat_data_c;
                    end else if (out_ready) begin
                        if (out_last) begin
                            state     <= ACCUM;
                            for (int unsigned c = 0; c < CHANNELS; c++) begin
                                sum[c] <= '0;
                            end
                            count     <= '0;
                            count_sat <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_chan  <= '0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                        end else begin
                            out_chan <= chan_next_c;
                            out_last <= (chan_next_c == CH_W'(CHANNELS - 1));
                            out_data <= beat_data_c;
                        end
                    end
                end

                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_avg_accumulator.sv
// Randomised bench for fix_avg_accumulator with a transaction-level reference model.
module tb_fix_avg_accumulator;

    localparam int unsigned CHANNELS  = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FRAC_BITS = 15;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned CH_W      = 2;
    localparam int          MAXCNT    = (1 << CNT_W) - 1;
    localparam logic [DATA_W-1:0] SENT = 32'hDEAD_BEEF;

    logic                       clk;
    logic                       reset;
    logic                       in_valid;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic                       in_ready;
    logic                       finish;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [CH_W-1:0]            out_chan;
    logic                       out_last;
    logic [CNT_W-1:0]           out_count;
    logic                       count_sat;
    logic                       busy;

    fix_avg_accumulator #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .finish   (finish),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_chan (out_chan),
        .out_last (out_last),
        .out_count(out_count),
        .count_sat(count_sat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = accumulating, 1 = computing, 2 = streaming beats.
    int     m_mode = 0;
    int     m_wait = 0;
    longint m_sum [CHANNELS];
    int     m_cnt = 0;
    bit     m_sat = 1'b0;
    longint m_recip = 0;
    int     m_beat = 0;

    function automatic logic [DATA_W-1:0] model_avg(input longint s, input longint r);
        longint p;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        lo = -(longint'(1) <<< (DATA_W - 1));
        p  = (s * r) >>> FRAC_BITS;
        if (p > hi) p = hi;
        if (p < lo) p = lo;
        return p[DATA_W-1:0];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CHANNELS; c++) m_sum[c] = 0;
        m_cnt  = 0;
        m_sat  = 1'b0;
        m_mode = 0;
        m_beat = 0;
    endtask

    always @(posedge clk) begin : model_p
        if (reset) begin
            model_clear();
        end else begin
            case (m_mode)
                0: begin
                    if (in_valid) begin
                        if (m_cnt < MAXCNT) begin
                            m_cnt++;
                            for (int c = 0; c < CHANNELS; c++)
                                m_sum[c] += longint'($signed(in_data[c*DATA_W +: DATA_W]));
                        end else begin
                            m_sat = 1'b1;
                        end
                    end
                    if (finish) begin
                        m_recip = (m_cnt == 0) ? 0 : (longint'(1) << FRAC_BITS) / m_cnt;
                        m_wait  = (m_cnt == 0) ? 1 : FRAC_BITS + 2;
                        m_mode  = 1;
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_mode = 2;
                        m_beat = 0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (m_beat == CHANNELS - 1) model_clear();
                        else m_beat++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare_p
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(m_mode == 0));
            check("busy", 64'(busy), 64'(m_mode != 0));
            check("out_valid", 64'(out_valid), 64'(m_mode == 2));
            check("count_sat", 64'(count_sat), 64'(m_sat));
            if (m_mode == 2) begin
                check("out_chan", 64'(out_chan), 64'(m_beat));
                check("out_last", 64'(out_last), 64'(m_beat == CHANNELS - 1));
                check("out_count", 64'(out_count), 64'(m_cnt));
                check("out_data", 64'(out_data), 64'(model_avg(m_sum[m_beat], m_recip)));
            end
        end
    end

    logic [DATA_W-1:0] got [CHANNELS];
    logic [CNT_W-1:0]  got_count;
    int                got_last_chan;

    function automatic logic [CHANNELS*DATA_W-1:0] rand_bus();
        logic [CHANNELS*DATA_W-1:0] v;
        for (int c = 0; c < CHANNELS; c++) v[c*DATA_W +: DATA_W] = $urandom;
        return v;
    endfunction

    task automatic send(input logic [CHANNELS*DATA_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand_bus();
    endtask

    // Pulse finish, measure edges to first out_valid, then collect every beat.
    // rmode: 0 ready held high, 1 five-cycle stall on beat 1, 2 random ready.
    task automatic run_finish(input int exp_lat, input int rmode);
        int lat;
        int stall_cnt;
        bit stalled;
        bit done;
        lat = -1;
        stall_cnt = 0;
        stalled = 1'b0;
        done = 1'b0;
        got_last_chan = -1;
        for (int c = 0; c < CHANNELS; c++) got[c] = SENT;
        out_ready = 1'b1;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("valid_latency", 64'(lat), 64'(exp_lat));
        if (lat < 0) return;
        got_count = out_count;
        for (int i = 0; i < 100 && !done; i++) begin
            if (out_valid) begin
                got[out_chan] = out_data;
                if (out_last) got_last_chan = int'(out_chan);
            end
            if (rmode == 1 && !stalled && out_valid && out_chan == 2'd1) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                stall_cnt = 5;
            end
            if (rmode == 2) begin
                out_ready = 1'($urandom_range(0, 1));
                finish    = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = rand_bus();
            end
            done = out_valid && out_ready && out_last;
            @(posedge clk);
            #1;
            finish = 1'b0;
            in_valid = 1'b0;
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) out_ready = 1'b1;
            end
        end
        check("stream_done", 64'(done), 64'd1);
        if (rmode == 1) check("stall_hit", 64'(stalled), 64'd1);
        out_ready = 1'b1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [CHANNELS*DATA_W-1:0] d;
        int  nsend;
        int  cnt;
        bit  found;

        reset = 1'b1;
        in_valid = 1'b0;
        finish = 1'b0;
        out_ready = 1'b1;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count_sat", 64'(count_sat), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_chan", 64'(out_chan), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        chk_en = 1'b1;

        // Lane 0 average of 1.0, 2.0, 3.0 with recip 0x2AAA.
        d = rand_bus(); d[31:0] = 32'h0000_8000; send(d);
        d = rand_bus(); d[31:0] = 32'h0001_0000; send(d);
        d = rand_bus(); d[31:0] = 32'h0001_8000; send(d);
        run_finish(FRAC_BITS + 2, 0);
        check("basic_beat0", 64'(got[0]), 64'h0000_FFFC);
        check("basic_count", 64'(got_count), 64'd3);

        // Two negative samples on lane 1.
        d = rand_bus(); d[63:32] = 32'hFFFF_8000; send(d);
        d = rand_bus(); d[63:32] = 32'hFFFF_8000; send(d);
        run_finish(FRAC_BITS + 2, 0);
        check("neg_beat1", 64'(got[1]), 64'hFFFF_8000);
        check("neg_count", 64'(got_count), 64'd2);

        // No samples at all.
        run_finish(1, 0);
        for (int c = 0; c < CHANNELS; c++) check("zero_beat", 64'(got[c]), 64'd0);
        check("zero_count", 64'(got_count), 64'd0);
        check("zero_last_chan", 64'(got_last_chan), 64'd3);

        // Backpressure in the middle of the stream.
        repeat (5) send(rand_bus());
        run_finish(FRAC_BITS + 2, 1);
        check("bp_last_chan", 64'(got_last_chan), 64'd3);
        for (int c = 0; c < CHANNELS; c++) check("bp_beat_seen", 64'(got[c] === SENT), 64'd0);

        // Count saturation.
        for (int c = 0; c < CHANNELS; c++) d[c*DATA_W +: DATA_W] = 32'h0000_8000;
        repeat (70) send(d);
        check("sat_flag", 64'(count_sat), 64'd1);
        check("sat_count", 64'(out_count), 64'd63);
        run_finish(FRAC_BITS + 2, 0);
        for (int c = 0; c < CHANNELS; c++) check("sat_beat", 64'(got[c]), 64'h0000_7FF8);
        check("sat_cleared", 64'(count_sat), 64'd0);

        // Sample presented together with finish is included.
        in_data = rand_bus();
        in_data[31:0] = 32'h0002_0000;
        in_valid = 1'b1;
        run_finish(FRAC_BITS + 2, 0);
        check("same_cycle_beat0", 64'(got[0]), 64'h0002_0000);
        check("same_cycle_count", 64'(got_count), 64'd1);

        // Randomised runs with gaps, random ready and ignored finish/in_valid.
        for (int r = 0; r < 12; r++) begin
            nsend = $urandom_range(0, 70);
            if (r == 0) nsend = 0;
            for (int s = 0; s < nsend; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send(rand_bus());
            end
            cnt = nsend;
            if ($urandom_range(0, 1) == 1) begin
                in_data = rand_bus();
                in_valid = 1'b1;
                cnt++;
            end
            if (cnt > MAXCNT) cnt = MAXCNT;
            run_finish((cnt == 0) ? 1 : FRAC_BITS + 2, 2);
        end

        // Reset while beat 2 is on the output.
        repeat (3) send(rand_bus());
        out_ready = 1'b1;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_chan == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_beat2", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_chan", 64'(out_chan), 64'd0);
        d = rand_bus(); d[31:0] = 32'h0001_2345; send(d);
        run_finish(FRAC_BITS + 2, 0);
        check("post_abort_beat0", 64'(got[0]), 64'h0001_2345);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
